// File: rtl/spiram_qpi.sv
// Behavioural SPI/QPI PSRAM device model: SPI and QPI command, address and data phases over a
// byte array, with page-wrapping bursts and configurable dummy cycles for fast reads.
module spiram_qpi #(
  parameter int unsigned MEM_BYTES   = 65536,
  parameter int unsigned PAGE_BYTES  = 1024,
  parameter int unsigned WAIT_CYCLES = 6
) (
  input  logic       clk48,
  input  logic       reset_n,
  input  logic       spi_ncs,
  input  logic [3:0] spi_sin,
  output logic [3:0] spi_sout,
  output logic       spi_oe
);

  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam int unsigned PW = $clog2(PAGE_BYTES);
  localparam bit HasWait = (WAIT_CYCLES != 0);
  localparam logic [4:0] WaitLast = HasWait ? 5'(WAIT_CYCLES - 1) : 5'd0;

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StWait, StRdata, StWdata, StIgnore
  } state_e;

  state_e      state_q, state_d;
  logic        qpi_q, qpi_d;
  logic [1:0]  mode_pend_q, mode_pend_d;  // {pending, new qpi value}
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  wsh_q, wsh_d;
  logic [3:0]  sout_d;
  logic        oe_d;
  logic [7:0]  mem [MEM_BYTES];

  logic        mem_we, present;
  logic [23:0] rd_addr;
  logic [2:0]  rd_idx;

  function automatic logic [23:0] addr_inc(input logic [23:0] a);
    logic [23:0] r;
    r = a;
    r[PW-1:0] = a[PW-1:0] + 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] unit_of(input logic [7:0] b, input logic [2:0] idx,
                                         input logic q);
    if (q) return idx[0] ? b[3:0] : b[7:4];
    return {2'b00, b[3'd7 - idx], 1'b0};
  endfunction

  logic [7:0]  cmd_full, wbyte;
  logic [23:0] addr_full, addr_nxt;
  logic        cmd_last, cmd_ok, is_read, has_wait, quad, addr_last, unit_last;

  assign cmd_full  = qpi_q ? {cmd_q[3:0], spi_sin} : {cmd_q[6:0], spi_sin[0]};
  assign cmd_last  = qpi_q ? (cnt_q == 5'd1) : (cnt_q == 5'd7);
  assign cmd_ok    = (cmd_full == 8'h03 && !qpi_q) || (cmd_full inside {8'h0B, 8'hEB, 8'h02, 8'h38});
  assign is_read   = cmd_q inside {8'h03, 8'h0B, 8'hEB};
  assign has_wait  = HasWait && (cmd_q inside {8'h0B, 8'hEB});
  assign quad      = qpi_q || cmd_q == 8'hEB || cmd_q == 8'h38;
  assign addr_last = quad ? (cnt_q == 5'd5) : (cnt_q == 5'd23);
  assign unit_last = quad ? (cnt_q == 5'd1) : (cnt_q == 5'd7);
  assign addr_full = quad ? {addr_q[19:0], spi_sin} : {addr_q[22:0], spi_sin[0]};
  assign wbyte     = quad ? {wsh_q[3:0], spi_sin} : {wsh_q[6:0], spi_sin[0]};
  assign addr_nxt  = addr_inc(addr_q);

  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      qpi_q       <= 1'b0;
      mode_pend_q <= 2'b00;
      cnt_q       <= 5'd0;
      cmd_q       <= 8'h00;
      addr_q      <= 24'h0;
      wsh_q       <= 8'h00;
      spi_sout    <= 4'h0;
      spi_oe      <= 1'b0;
    end else begin
      state_q     <= state_d;
      qpi_q       <= qpi_d;
      mode_pend_q <= mode_pend_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      wsh_q       <= wsh_d;
      spi_sout    <= sout_d;
      spi_oe      <= oe_d;
    end
  end

  // Array is never reset; writes are gated by the (reset) FSM state.
  always_ff @(posedge clk48) begin
    if (mem_we) mem[addr_q[AW-1:0]] <= wbyte;
  end

  always_comb begin
    state_d = state_q;
    if (spi_ncs) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StCmd;
        StCmd:   if (cmd_last) state_d = cmd_ok ? StAddr : StIgnore;
        StAddr:  if (addr_last) state_d = !is_read ? StWdata : (has_wait ? StWait : StRdata);
        StWait:  if (cnt_q == WaitLast) state_d = StRdata;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    qpi_d       = qpi_q;
    mode_pend_d = mode_pend_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    wsh_d       = wsh_q;
    mem_we      = 1'b0;
    present     = 1'b0;
    rd_addr     = addr_q;
    rd_idx      = 3'd0;
    if (spi_ncs) begin
      cnt_d       = 5'd0;
      mode_pend_d = 2'b00;
      if (mode_pend_q[1]) qpi_d = mode_pend_q[0];
    end else begin
      unique case (state_q)
        StIdle: begin
          cmd_d = qpi_q ? {4'h0, spi_sin} : {7'h00, spi_sin[0]};
          cnt_d = 5'd1;
        end
        StCmd: begin
          cmd_d = cmd_full;
          cnt_d = cmd_last ? 5'd0 : cnt_q + 5'd1;
          if (cmd_last && cmd_full == 8'h35) mode_pend_d = 2'b11;
          if (cmd_last && cmd_full == 8'hF5) mode_pend_d = 2'b10;
        end
        StAddr: begin
          addr_d = addr_full;
          cnt_d  = addr_last ? 5'd0 : cnt_q + 5'd1;
          if (addr_last && is_read && !has_wait) begin
            present = 1'b1;
            rd_addr = addr_full;
          end
        end
        StWait: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == WaitLast) begin
            cnt_d   = 5'd0;
            present = 1'b1;
          end
        end
        StRdata: begin
          present = 1'b1;
          if (unit_last) begin
            cnt_d   = 5'd0;
            addr_d  = addr_nxt;
            rd_addr = addr_nxt;
          end else begin
            cnt_d  = cnt_q + 5'd1;
            rd_idx = 3'(cnt_q + 5'd1);
          end
        end
        StWdata: begin
          wsh_d = wbyte;
          if (unit_last) begin
            mem_we = 1'b1;
            cnt_d  = 5'd0;
            addr_d = addr_nxt;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        // Any clock beyond the command cancels a pending mode switch.
        StIgnore: mode_pend_d = 2'b00;
        default: ;
      endcase
    end
    oe_d   = present;
    sout_d = present ? unit_of(mem[rd_addr[AW-1:0]], rd_idx, quad) : 4'h0;
  end

endmodule

// File: tb/tb_spiram_qpi.sv
// Directed bench for spiram_qpi: a byte-array model feeds a scoreboard of expected {oe, sout}
// values that are compared after each clock of the read phases.
module tb_spiram_qpi;
  logic       clk48 = 1'b0;
  logic       reset_n;
  logic       spi_ncs;
  logic [3:0] spi_sin;
  logic [3:0] spi_sout;
  logic       spi_oe;

  int checks = 0;
  int errors = 0;
  logic [4:0] sb[$];
  logic [7:0] mdl [65536];
  bit qpi_m = 1'b0;

  always #5 clk48 = ~clk48;

  spiram_qpi #(.MEM_BYTES(65536), .PAGE_BYTES(1024), .WAIT_CYCLES(6)) dut (
    .clk48   (clk48),
    .reset_n (reset_n),
    .spi_ncs (spi_ncs),
    .spi_sin (spi_sin),
    .spi_sout(spi_sout),
    .spi_oe  (spi_oe)
  );

  function automatic logic [23:0] inc_addr(input logic [23:0] a);
    return {a[23:10], a[9:0] + 10'd1};
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed oe/sout=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [3:0] s);
    spi_ncs = 1'b0;
    spi_sin = s;
    @(posedge clk48);
    @(negedge clk48);
  endtask

  task automatic cs_high();
    spi_ncs = 1'b1;
    spi_sin = 4'h0;
    @(posedge clk48);
    @(negedge clk48);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit quad);
    if (quad) begin
      tick(b[7:4]);
      tick(b[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) tick({3'b000, b[i]});
    end
  endtask

  task automatic send_cmd(input logic [7:0] c);
    send_byte(c, qpi_m);
  endtask

  task automatic send_addr(input logic [23:0] a, input bit quad);
    if (quad) begin
      for (int i = 5; i >= 0; i--) tick(a[4*i +: 4]);
    end else begin
      for (int i = 23; i >= 0; i--) tick({3'b000, a[i]});
    end
  endtask

  task automatic write2(input logic [7:0] cmd, input logic [23:0] a, input logic [7:0] d0,
                        input logic [7:0] d1, input bit quad);
    logic [23:0] p;
    send_cmd(cmd);
    send_addr(a, quad);
    send_byte(d0, quad);
    mdl[a[15:0]] = d0;
    p = inc_addr(a);
    send_byte(d1, quad);
    mdl[p[15:0]] = d1;
    cs_high();
  endtask

  task automatic push_read(input logic [23:0] a, input int nbytes, input int waits,
                           input bit quad);
    logic [7:0]  b;
    logic [23:0] p;
    p = a;
    repeat (waits) sb.push_back(5'h00);
    for (int k = 0; k < nbytes; k++) begin
      b = mdl[p[15:0]];
      if (quad) begin
        sb.push_back({1'b1, b[7:4]});
        sb.push_back({1'b1, b[3:0]});
      end else begin
        for (int i = 7; i >= 0; i--) sb.push_back({1'b1, 2'b00, b[i], 1'b0});
      end
      p = inc_addr(p);
    end
  endtask

  // First entry is compared right after the edge already taken, then one clock per entry.
  task automatic drain(input string tag);
    int n;
    logic [4:0] exp;
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick(4'h0);
      exp = sb.pop_front();
      check(tag, {spi_oe, spi_sout}, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    spi_ncs = 1'b1;
    spi_sin = 4'h0;
    repeat (3) @(negedge clk48);
    check("reset_outputs", {spi_oe, spi_sout}, 5'h00);
    reset_n = 1'b1;
    cs_high();

    // SPI write then single-lane read; oe must stay low until the last address bit.
    write2(8'h02, 24'h000010, 8'hA5, 8'h3C, 1'b0);
    send_cmd(8'h03);
    push_read(24'h000010, 2, 0, 1'b0);
    for (int i = 23; i > 0; i--) tick({3'b000, 1'(24'h000010 >> i)});
    check("spi_read_pre_oe", {spi_oe, spi_sout}, 5'h00);
    tick(4'h0);
    drain("spi_read");
    cs_high();
    check("cs_high_idle", {spi_oe, spi_sout}, 5'h00);

    // Quad read with dummy cycles.
    send_cmd(8'hEB);
    push_read(24'h000010, 2, 6, 1'b1);
    send_addr(24'h000010, 1'b1);
    drain("quad_read");
    cs_high();

    // Enter QPI, quad write across a page boundary, read back through the wrap.
    send_cmd(8'h35);
    cs_high();
    qpi_m = 1'b1;
    write2(8'h38, 24'h0003FF, 8'h11, 8'h22, 1'b1);
    send_cmd(8'hEB);
    push_read(24'h0003FF, 2, 6, 1'b1);
    send_addr(24'h0003FF, 1'b1);
    drain("qpi_wrap_read");
    cs_high();
    send_cmd(8'h03);
    repeat (5) sb.push_back(5'h00);
    drain("qpi_03_ignore");
    cs_high();

    // Exit QPI, SPI fast read across the wrap.
    send_cmd(8'hF5);
    cs_high();
    qpi_m = 1'b0;
    send_cmd(8'h0B);
    push_read(24'h0003FF, 2, 6, 1'b0);
    send_addr(24'h0003FF, 1'b0);
    drain("fast_read");
    cs_high();

    // An extra clock after 0x35 must cancel the mode switch: 0x03 still works.
    send_cmd(8'h35);
    tick(4'h0);
    cs_high();
    send_cmd(8'h03);
    push_read(24'h000010, 1, 0, 1'b0);
    send_addr(24'h000010, 1'b0);
    drain("mode_extra_clk");
    cs_high();

    // Partial byte discarded on chip-select rise.
    write2(8'h02, 24'h000100, 8'hAB, 8'hCD, 1'b0);
    send_cmd(8'h38);
    send_addr(24'h000100, 1'b1);
    tick(4'h7);
    tick(4'h8);
    tick(4'h9);
    cs_high();
    mdl[16'h0100] = 8'h78;
    send_cmd(8'hEB);
    push_read(24'h000100, 2, 6, 1'b1);
    send_addr(24'h000100, 1'b1);
    drain("partial_write");
    cs_high();

    // Reset in the middle of a QPI read.
    send_cmd(8'h35);
    cs_high();
    qpi_m = 1'b1;
    send_cmd(8'hEB);
    push_read(24'h000010, 1, 6, 1'b1);
    send_addr(24'h000010, 1'b1);
    drain("qpi_read_before_reset");
    #2 reset_n = 1'b0;
    #1 check("reset_async", {spi_oe, spi_sout}, 5'h00);
    @(posedge clk48);
    @(negedge clk48);
    reset_n = 1'b1;
    qpi_m = 1'b0;
    cs_high();
    send_cmd(8'h03);
    push_read(24'h000010, 2, 0, 1'b0);
    send_addr(24'h000010, 1'b0);
    drain("post_reset_read");
    cs_high();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spiram_qpi.md
SPIRAM_QPI -- requirements
Module: spiram_qpi

Interface
REQ-001 The module SHALL have parameter MEM_BYTES, default 65536, meaning array depth in bytes (power of two).
REQ-002 The module SHALL have parameter PAGE_BYTES, default 1024, meaning burst wrap boundary in bytes (power of two, <= MEM_BYTES).
REQ-003 The module SHALL have parameter WAIT_CYCLES, default 6, meaning dummy clocks for fast/quad reads (0..15).
REQ-004 clk48  input  1  sampling clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-006 spi_ncs  input  1  chip select, active-low.
REQ-007 spi_sin  input  4  IO0..IO3 input lanes.
REQ-008 spi_sout  output  4  IO0..IO3 output lanes, registered.
REQ-009 spi_oe  output  1  high while the model drives spi_sout.

Function
REQ-010 The FSM SHALL have states IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE.
REQ-011 Any edge with spi_ncs=1 SHALL force IDLE, spi_oe=0, spi_sout=0, clear bit/nibble counters; the mode register is kept.
REQ-012 IDLE with spi_ncs=0 SHALL sample the first command bit/nibble on the same edge and enter CMD.
REQ-013 In SPI mode (qpi=0) the command SHALL be 8 bits on spi_sin[0], MSB first; in QPI mode (qpi=1) 2 nibbles on spi_sin[3:0], high nibble first.
REQ-014 Commands: 0x03 read, 0x0B fast read, 0xEB quad read, 0x02 write, 0x38 quad write, 0x35 enter QPI, 0xF5 exit QPI; any other code, and 0x03 in QPI mode, SHALL go to IGNORE until spi_ncs=1.
REQ-015 0x35 SHALL set qpi=1 and 0xF5 SHALL set qpi=0 at spi_ncs rising (first edge with spi_ncs=1), only if exactly 8 command bit-times were received.
REQ-016 Address SHALL be 24 bits MSB first: 24 clocks on spi_sin[0] for 0x03/0x0B/0x02 in SPI mode; 6 nibbles for 0xEB/0x38 or any QPI-mode command.
REQ-017 The effective address SHALL be addr mod MEM_BYTES.
REQ-018 0x0B and 0xEB SHALL pass WAIT_CYCLES clocks in WAIT after the last address edge; 0x03 SHALL have zero wait.
REQ-019 Read latency: on the edge ending ADDR (or WAIT), spi_oe SHALL go 1 and spi_sout SHALL present the first data unit; each following edge presents the next.
REQ-020 Quad-lane reads (0xEB, or any read in QPI) SHALL output the high nibble, then the low nibble, per byte on spi_sout[3:0].
REQ-021 Single-lane reads SHALL output bits MSB first on spi_sout[1]; spi_sout[0], [3:2] SHALL be 0.
REQ-022 Writes SHALL assemble bytes in the same lane order as reads and commit each byte to the array on the edge receiving its last bit/nibble.
REQ-023 A partial byte at spi_ncs rising SHALL be discarded.
REQ-024 After each byte, address SHALL increment with the low log2(PAGE_BYTES) bits wrapping and upper bits unchanged.
REQ-025 spi_oe SHALL be 0 in every state except RDATA.
REQ-026 Read after write to the same address within one clock SHALL return the newly written byte (no read-during-write hazard across transactions).

Reset
REQ-027 reset_n=0 SHALL asynchronously force IDLE, qpi=0, spi_oe=0, spi_sout=4'h0, counters 0.
REQ-028 Array contents SHALL NOT be cleared by reset.
REQ-029 Reset assertion mid-transaction SHALL abort it; no further byte is committed.

Verification
REQ-030 SPI 0x02, addr 0x000010, data 0xA5,0x3C; then 0x03 addr 0x000010 -> spi_sout[1] bits 10100101 00111100, spi_oe=1 from edge after last address bit.
REQ-031 0xEB addr 0x000010 with WAIT_CYCLES=6 -> 6 edges spi_oe=0, then nibbles A,5,3,C on spi_sout.
REQ-032 0x35 then QPI 0x38 addr 0x0003FF data 0x11,0x22 -> 0x11 at 0x3FF, 0x22 at 0x000 (page wrap); QPI 0x03 -> IGNORE, spi_oe stays 0.
REQ-033 0xF5 in QPI mode, then SPI 0x0B addr 0x0003FF -> 8 bits of 0x11 after 6 dummy clocks.
REQ-034 Write 0x38 with 3 nibbles 0x7,0x8,0x9 then spi_ncs=1 -> only 0x78 committed; next byte unchanged.
REQ-035 reset_n=0 during RDATA -> spi_oe=0, spi_sout=0 immediately; qpi=0 after release; memory intact on re-read.
